id_stage_interlocked: RTL
=========================

Name: id_stage_interlocked

Overview:
Next-generation decode stage. It combines a parametrised register file with a write-through bypass, a decoder covering R/J/BEQ/BNE/ADDI/LW/SW, and a branch unit that resolves in ID. A load-use/branch hazard interlock inserts bubbles when operands are not ready. An integrated ID/EX pipeline register makes all EX-bound outputs registered. Sits between the IF/ID register and the EX stage; the interlock stall drives the PC and IF/ID enables.

Parameters:
LEN_WORD, 32, datapath width; must be >= 28.
LEN_REG_FILE_ADDR, 5, register address width.
SIZE_REG_FILE, 32, number of registers; must be <= 2**LEN_REG_FILE_ADDR.
LEN_OP_CODE, 6, opcode field width (instruction[31:26]).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  IF/ID holds a real instruction.
inced_pc  in  LEN_WORD  PC+4 of the ID instruction.
instruction  in  32  ID instruction.
ex_reg_write_i, ex_mem_read_i  in  1  EX-stage control, for hazard checks.
ex_write_reg_i  in  LEN_REG_FILE_ADDR  EX destination register.
mem_reg_write_i, mem_mem_read_i  in  1  MEM-stage control.
mem_write_reg_i  in  LEN_REG_FILE_ADDR  MEM destination register.
alu_out_m  in  LEN_WORD  MEM-stage ALU result, forwarded to the branch compare.
reg_write_wb  in  1  WB write enable.
write_reg_wb  in  LEN_REG_FILE_ADDR  WB destination register.
write_data_reg  in  LEN_WORD  WB write data.
id_stall  out  1  combinational; freeze PC and IF/ID.
pc_src  out  1  combinational; redirect fetch.
jump_pc  out  LEN_WORD  combinational branch/jump target.
ex_valid  out  1  registered; ID/EX slot holds a real instruction.
ex_read_data_1, ex_read_data_2, ex_extended_imm  out  LEN_WORD  registered operands.
ex_rs, ex_rt, ex_rd  out  LEN_REG_FILE_ADDR  registered register specifiers.
ex_alu_op  out  3  registered ALU operation.
ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered control.
ex_illegal  out  1  registered; unknown opcode.
perf_stall_cycles, perf_taken  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset (reset=0, async): all registers and every registered output = 0; FSM = RUN.
- Register file:
  - Register 0 reads 0 and ignores writes.
  - Write on clk rising edge when reg_write_wb=1 and write_reg_wb!=0.
  - Reads are combinational. If WB writes the same non-zero address in the same cycle, the read returns write_data_reg (bypass).
  - Addresses >= SIZE_REG_FILE read 0; writes to them are ignored.
- Decode, opcode to {alu_op, reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg}:
  - 0x00 R: 010,1,0,0,0,1,0
  - 0x23 LW: 000,0,1,1,0,1,1
  - 0x2B SW: 000,0,1,0,1,0,0
  - 0x04 BEQ and 0x05 BNE: 001, all control 0
  - 0x08 ADDI: 011,0,1,0,0,1,0
  - 0x02 J: all 0
  - Any other opcode: all control 0, illegal=1.
- Operand use: rs is used by R/LW/SW/BEQ/BNE/ADDI. rt is used by R/SW/BEQ/BNE.
- Stall, asserted only when in_valid=1; "match" means equal to a used, non-zero operand:
  - (a) ex_mem_read_i and ex_write_reg_i matches.
  - (b) BEQ/BNE and ex_reg_write_i and ex_write_reg_i matches.
  - (c) BEQ/BNE and mem_mem_read_i and mem_write_reg_i matches.
  - A branch after an LW in EX therefore stalls 2 cycles; after an ALU op in EX, 1 cycle.
- FSM:
  - States: RUN, STALL. Next state = STALL if the stall condition holds, else RUN.
  - The state is used only by the perf counters; id_stall itself is purely combinational.
- Branch compare operands:
  - Use alu_out_m when mem_reg_write_i=1, mem_mem_read_i=0, and mem_write_reg_i equals the source (non-zero).
  - Otherwise use the register file output.
- pc_src = in_valid & !id_stall & (BEQ&eq | BNE&!eq | J).
- jump_pc:
  - Branch: inced_pc + (sign_extend(instruction[15:0]) << 2), modulo 2**LEN_WORD.
  - J: {inced_pc[LEN_WORD-1:28], instruction[25:0], 2'b00}.
- extended_imm = sign_extend(instruction[15:0]) to LEN_WORD.
- ID/EX register, each clk rising edge:
  - If in_valid & !id_stall: capture operands, specifiers (rs=[25:21], rt=[20:16], rd=[15:11]), control, illegal; set ex_valid=1.
  - Otherwise load a bubble: every ex_* output = 0.
- A taken branch does not flush ID/EX; the branch itself writes nothing.
- Reset asserted mid-stall: bubble is immediate, FSM returns to RUN.

Optional Feature:
Macro ID_PERF_COUNTERS_EN.
- Defined:
  - perf_stall_cycles increments on each cycle where id_stall=1.
  - perf_taken increments on each cycle where pc_src=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset low mid-run -> all ex_* = 0, ex_valid=0; a read of r7 returns 0.
- WB writes r5=0x00001234 while ID is ADD rs=5 -> next cycle ex_read_data_1=0x00001234.
- EX holds LW r3; ID holds ADD r4,r3,r2 -> id_stall=1 for 1 cycle, then a bubble (ex_valid=0), then ADD issues with ex_rs=3.
- BEQ r1,r2 with r1=5, MEM forwards r2=5, imm=0xFFFF, inced_pc=0x100 -> pc_src=1, jump_pc=0xFC; the same case as BNE -> pc_src=0.
- LW r2 in EX, then BEQ r1,r2 -> id_stall for 2 cycles; perf_stall_cycles=2 with ID_PERF_COUNTERS_EN.
- J, instruction[25:0]=0x0000010, inced_pc=0x40000004 -> jump_pc=0x40000040, pc_src=1; opcode 0x3F -> ex_illegal=1 and all control 0.

Source files
------------

// File: rtl/id_stage_interlocked.sv
// -----------------------------------------------------------------------------
// id_stage_interlocked
//   Decode stage: register file with write-through bypass, R/J/BEQ/BNE/ADDI/
//   LW/SW decoder, branch unit resolving in ID, load-use/branch hazard
//   interlock and an integrated ID/EX pipeline register.
//
// Optional feature macro: ID_PERF_COUNTERS_EN
//   defined   -> saturating stall-cycle and taken-redirect counters
//   undefined -> perf_* outputs tied to 0, no counter flops
//
// Ports
//   clk, reset          clock (rising), async active-low reset
//   in_valid            IF/ID holds a real instruction
//   inced_pc            PC+4 of the ID instruction
//   instruction         ID instruction word
//   ex_* _i / mem_* _i  EX / MEM control used for hazard checks + forwarding
//   alu_out_m           MEM ALU result, forwarded into the branch compare
//   reg_write_wb, write_reg_wb, write_data_reg   WB register write port
//   id_stall            comb: freeze PC and IF/ID
//   pc_src, jump_pc     comb: fetch redirect and its target
//   ex_*                registered ID/EX slot contents
//   perf_stall_cycles, perf_taken   performance counters
// -----------------------------------------------------------------------------
module id_stage_interlocked #(
  parameter int LEN_WORD          = 32, // must be >= 28
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int SIZE_REG_FILE     = 32, // must be <= 2**LEN_REG_FILE_ADDR
  parameter int LEN_OP_CODE       = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [LEN_WORD-1:0]          inced_pc,
  input  logic [31:0]                  instruction,
  input  logic                         ex_reg_write_i,
  input  logic                         ex_mem_read_i,
  input  logic [LEN_REG_FILE_ADDR-1:0] ex_write_reg_i,
  input  logic                         mem_reg_write_i,
  input  logic                         mem_mem_read_i,
  input  logic [LEN_REG_FILE_ADDR-1:0] mem_write_reg_i,
  input  logic [LEN_WORD-1:0]          alu_out_m,
  input  logic                         reg_write_wb,
  input  logic [LEN_REG_FILE_ADDR-1:0] write_reg_wb,
  input  logic [LEN_WORD-1:0]          write_data_reg,
  output logic                         id_stall,
  output logic                         pc_src,
  output logic [LEN_WORD-1:0]          jump_pc,
  output logic                         ex_valid,
  output logic [LEN_WORD-1:0]          ex_read_data_1,
  output logic [LEN_WORD-1:0]          ex_read_data_2,
  output logic [LEN_WORD-1:0]          ex_extended_imm,
  output logic [LEN_REG_FILE_ADDR-1:0] ex_rs,
  output logic [LEN_REG_FILE_ADDR-1:0] ex_rt,
  output logic [LEN_REG_FILE_ADDR-1:0] ex_rd,
  output logic [2:0]                   ex_alu_op,
  output logic                         ex_reg_dst,
  output logic                         ex_alu_src,
  output logic                         ex_mem_read,
  output logic                         ex_mem_write,
  output logic                         ex_reg_write,
  output logic                         ex_mem_to_reg,
  output logic                         ex_illegal,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_taken
);

  localparam int A = LEN_REG_FILE_ADDR;
  localparam int W = LEN_WORD;

  localparam logic [LEN_OP_CODE-1:0] OP_R    = LEN_OP_CODE'(6'h00);
  localparam logic [LEN_OP_CODE-1:0] OP_J    = LEN_OP_CODE'(6'h02);
  localparam logic [LEN_OP_CODE-1:0] OP_BEQ  = LEN_OP_CODE'(6'h04);
  localparam logic [LEN_OP_CODE-1:0] OP_BNE  = LEN_OP_CODE'(6'h05);
  localparam logic [LEN_OP_CODE-1:0] OP_ADDI = LEN_OP_CODE'(6'h08);
  localparam logic [LEN_OP_CODE-1:0] OP_LW   = LEN_OP_CODE'(6'h23);
  localparam logic [LEN_OP_CODE-1:0] OP_SW   = LEN_OP_CODE'(6'h2B);

  typedef enum logic {RUN, STALL} state_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [LEN_OP_CODE-1:0] opcode;
  logic [A-1:0]           rs, rt, rd;
  logic [W-1:0]           ext_imm;

  assign opcode  = instruction[31 -: LEN_OP_CODE];
  assign rs      = A'(instruction[25:21]);
  assign rt      = A'(instruction[20:16]);
  assign rd      = A'(instruction[15:11]);
  assign ext_imm = {{(W-16){instruction[15]}}, instruction[15:0]};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [W-1:0] regs [SIZE_REG_FILE];
  logic [W-1:0] rd_data_1, rd_data_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE_REG_FILE; i++) regs[i] <= '0;
    end else if (reg_write_wb && write_reg_wb != '0 &&
                 32'(write_reg_wb) < SIZE_REG_FILE) begin
      regs[write_reg_wb] <= write_data_reg;
    end
  end

  // r0 and out-of-range addresses read zero; a same-cycle WB write to the
  // address is passed straight through so ID never sees a stale value.
  function automatic logic [W-1:0] rf_read(input logic [A-1:0] addr);
    logic [W-1:0] val;
    val = '0;
    if (addr != '0 && 32'(addr) < SIZE_REG_FILE) begin
      if (reg_write_wb && write_reg_wb == addr) val = write_data_reg;
      else                                      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    rd_data_1 = rf_read(rs);
    rd_data_2 = rf_read(rt);
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [2:0] alu_op;
  logic       reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  logic       illegal, use_rs, use_rt, is_beq, is_bne, is_j;

  always_comb begin
    alu_op     = 3'b000;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op = 3'b010; reg_dst = 1'b1; reg_write = 1'b1;
        use_rs = 1'b1;   use_rt  = 1'b1;
      end
      OP_LW: begin
        alu_op = 3'b000; alu_src = 1'b1; mem_read = 1'b1;
        reg_write = 1'b1; mem_to_reg = 1'b1; use_rs = 1'b1;
      end
      OP_SW: begin
        alu_op = 3'b000; alu_src = 1'b1; mem_write = 1'b1;
        use_rs = 1'b1;   use_rt  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = 3'b001; is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BNE: begin
        alu_op = 3'b001; is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_ADDI: begin
        alu_op = 3'b011; alu_src = 1'b1; reg_write = 1'b1; use_rs = 1'b1;
      end
      OP_J:    is_j    = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard interlock
  // ---------------------------------------------------------------------------
  logic is_br;
  assign is_br = is_beq | is_bne;

  // A producer only matters if it targets a non-zero register this
  // instruction actually reads.
  function automatic logic hits(input logic [A-1:0] dst);
    return (use_rs && rs != '0 && dst == rs) ||
           (use_rt && rt != '0 && dst == rt);
  endfunction

  always_comb begin
    id_stall = in_valid &&
               ((ex_mem_read_i && hits(ex_write_reg_i)) ||
                (is_br && ex_reg_write_i && hits(ex_write_reg_i)) ||
                (is_br && mem_mem_read_i && hits(mem_write_reg_i)));
  end

  // ---------------------------------------------------------------------------
  // Branch unit
  // ---------------------------------------------------------------------------
  // A MEM-stage ALU result is ready to forward; a MEM-stage load is not
  // (that case has already stalled above).
  logic         fwd_a, fwd_b, br_eq;
  logic [W-1:0] cmp_a, cmp_b, br_target, j_target;

  assign fwd_a = mem_reg_write_i && !mem_mem_read_i &&
                 mem_write_reg_i != '0 && mem_write_reg_i == rs;
  assign fwd_b = mem_reg_write_i && !mem_mem_read_i &&
                 mem_write_reg_i != '0 && mem_write_reg_i == rt;
  assign cmp_a = fwd_a ? alu_out_m : rd_data_1;
  assign cmp_b = fwd_b ? alu_out_m : rd_data_2;
  assign br_eq = (cmp_a == cmp_b);

  always_comb begin
    br_target = inced_pc + (ext_imm << 2);
    // Region jump keeps the PC bits above the 28-bit jump field.
    j_target        = inced_pc;
    j_target[27:0]  = {instruction[25:0], 2'b00};
    jump_pc         = is_j ? j_target : br_target;
    pc_src          = in_valid && !id_stall &&
                      ((is_beq && br_eq) || (is_bne && !br_eq) || is_j);
  end

  // ---------------------------------------------------------------------------
  // RUN/STALL state
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (id_stall) state_d = STALL;
  end

  // The state is observational only; nothing in the datapath depends on it.
  logic unused_state;
  assign unused_state = ^state_q;

  // ---------------------------------------------------------------------------
  // ID/EX register: capture on issue, otherwise load a bubble. A taken
  // branch still issues (it writes nothing downstream).
  // ---------------------------------------------------------------------------
  logic issue;
  assign issue = in_valid && !id_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid        <= 1'b0;
      ex_read_data_1  <= '0;
      ex_read_data_2  <= '0;
      ex_extended_imm <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
      ex_alu_op       <= '0;
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_illegal      <= 1'b0;
    end else if (issue) begin
      ex_valid        <= 1'b1;
      ex_read_data_1  <= rd_data_1;
      ex_read_data_2  <= rd_data_2;
      ex_extended_imm <= ext_imm;
      ex_rs           <= rs;
      ex_rt           <= rt;
      ex_rd           <= rd;
      ex_alu_op       <= alu_op;
      ex_reg_dst      <= reg_dst;
      ex_alu_src      <= alu_src;
      ex_mem_read     <= mem_read;
      ex_mem_write    <= mem_write;
      ex_reg_write    <= reg_write;
      ex_mem_to_reg   <= mem_to_reg;
      ex_illegal      <= illegal;
    end else begin
      ex_valid        <= 1'b0;
      ex_read_data_1  <= '0;
      ex_read_data_2  <= '0;
      ex_extended_imm <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
      ex_alu_op       <= '0;
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_illegal      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef ID_PERF_COUNTERS_EN
  logic [31:0] stall_cnt, taken_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (pc_src   && taken_cnt != '1) taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_taken        = taken_cnt;
`else
  assign perf_stall_cycles = '0;
  assign perf_taken        = '0;
`endif

endmodule
